div_radix2: RTL

Iterative unsigned radix-2 restoring divider that supplies quotient and remainder to the M-extension unit in the execute stage. The M-extension unit converts signed operands to magnitudes and fixes up result signs, so this block sees only unsigned operands. Each division is launched by a start pulse and completes with a one-cycle done strobe. Results stay held until the next accepted start.

---
 rtl/div_radix2_pkg.sv | 19 +
 rtl/div_radix2_lzc.sv | 22 ++
 rtl/div_radix2.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/div_radix2_pkg.sv
// Shared M-extension divider definitions: FSM state type and counter sizing.
package div_radix2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } type_div_states_e;

   localparam int DIV_XLEN = 32;

   function automatic int div_cnt_w(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

   // Wide enough to hold XLEN itself, not just XLEN-1.
   localparam int DIV_CNT_W = div_cnt_w(DIV_XLEN);

endpackage

// File: rtl/div_radix2_lzc.sv
// div_lzc: leading-zero counter; an all-zero input reports XLEN.
module div_lzc
   import div_radix2_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = div_cnt_w(XLEN)
) (
   input  logic [XLEN-1:0]  value,
   output logic [CNT_W-1:0] count
);

   // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
   always_comb begin
      count = CNT_W'(XLEN);
      for (int i = 0; i < XLEN; i++) begin
         if (value[i]) begin
            count = CNT_W'(XLEN - 1 - i);
         end
      end
   end

endmodule

// File: rtl/div_radix2.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per cycle.
// Optional DIV_EARLY_TERM_EN skips the dividend's leading zeros.
module div_radix2
   import div_radix2_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] opr1_i,
   input  logic [XLEN-1:0] opr2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o
);

   localparam int CNT_W = div_cnt_w(XLEN);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);

   type_div_states_e state_reg, state_next;

   logic [XLEN-1:0]  rem_reg, dvd_reg, dvs_reg;
   logic [XLEN-1:0]  quo_out_reg, rem_out_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [XLEN:0]    shift_rem, diff;
   logic [XLEN-1:0]  rem_step, dvd_step;
   logic [XLEN-1:0]  dvd_init;
   logic [CNT_W-1:0] cnt_init;
   logic             dvs_zero, dvd_zero_fast, last_step;

`ifdef DIV_EARLY_TERM_EN
   logic [CNT_W-1:0] lz_cnt;

   div_lzc #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_lzc (
      .value (opr1_i),
      .count (lz_cnt)
   );

   assign dvd_init      = opr1_i << lz_cnt;
   assign cnt_init      = CNT_FULL - lz_cnt;
   assign dvd_zero_fast = (lz_cnt == CNT_FULL);
`else
   assign dvd_init      = opr1_i;
   assign cnt_init      = CNT_FULL;
   assign dvd_zero_fast = 1'b0;
`endif

   assign dvs_zero  = (opr2_i == '0);
   assign last_step = (state_reg == BUSY) && (cnt_reg == CNT_W'(1));

   // Trial subtraction: bit XLEN of diff is the borrow, i.e. the negative flag.
   assign shift_rem = {rem_reg, dvd_reg[XLEN-1]};
   assign diff      = shift_rem - {1'b0, dvs_reg};
   assign rem_step  = diff[XLEN] ? shift_rem[XLEN-1:0] : diff[XLEN-1:0];
   assign dvd_step  = {dvd_reg[XLEN-2:0], ~diff[XLEN]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (abort_i) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  state_next = (dvs_zero || dvd_zero_fast) ? DONE : BUSY;
               end
            end
            BUSY: begin
               if (last_step) begin
                  state_next = DONE;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_reg     <= '0;
         dvd_reg     <= '0;
         dvs_reg     <= '0;
         cnt_reg     <= '0;
         quo_out_reg <= '0;
         rem_out_reg <= '0;
      end else if (abort_i) begin
         cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  dvs_reg <= opr2_i;
                  dvd_reg <= dvd_init;
                  rem_reg <= '0;
                  cnt_reg <= cnt_init;
                  if (dvs_zero) begin
                     quo_out_reg <= '1;
                     rem_out_reg <= opr1_i;
                  end else if (dvd_zero_fast) begin
                     quo_out_reg <= '0;
                     rem_out_reg <= '0;
                  end
               end
            end
            BUSY: begin
               rem_reg <= rem_step;
               dvd_reg <= dvd_step;
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (last_step) begin
                  quo_out_reg <= dvd_step;
                  rem_out_reg <= rem_step;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o = (state_reg == BUSY) || (state_reg == DONE);
   assign done_o = (state_reg == DONE) && !abort_i;
   assign quo_o  = quo_out_reg;
   assign rem_o  = rem_out_reg;

endmodule
